// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the MEM stage: word-organised synchronous RAM,
// sign/zero-extended loads, word stores, and read-modify-write byte/half stores.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_write_addr,
  input  logic [31:0] data_mem_write_data,
  input  logic        data_mem_read_enable,
  input  logic [31:0] data_mem_read_addr,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] data_mem_read_data,
  output logic        mem_stall,
  output logic        mem_misaligned
);

  typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;

  state_t            state, state_next;
  logic              req, accept, fault_in, unused_addr_bits;
  logic [31:0]       addr_in;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              unsigned_q, store_q, fault_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ram [DEPTH_WORDS];
  logic [31:0]       rdata_q, merged, load_ext, ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_we, ram_re;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;

  assign req              = data_mem_read_enable | data_mem_write_enable;
  assign accept           = (state == IDLE) && req;
  assign addr_in          = data_mem_write_enable ? data_mem_write_addr : data_mem_read_addr;
  // Upper address bits wrap modulo the RAM depth.
  assign unused_addr_bits = ^addr_in[31:ADDR_W+2];

  always_comb begin
    fault_in = 1'b0;
    case (mem_size)
      2'b00:   fault_in = 1'b0;
      2'b01:   fault_in = addr_in[0];
      default: fault_in = |addr_in[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!fault_in && data_mem_write_enable && !mem_size[1]) state_next = MERGE;
          else                                                      state_next = DONE;
        end
      end
      MERGE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      fault_q    <= 1'b0;
      wdata_q    <= '0;
    end else if (accept) begin
      addr_q     <= addr_in[ADDR_W+1:0];
      size_q     <= mem_size;
      unsigned_q <= mem_unsigned;
      store_q    <= data_mem_write_enable;
      fault_q    <= fault_in;
      wdata_q    <= data_mem_write_data;
    end
  end

  // Word stores skip the read; a reset edge never commits a write, even from MERGE.
  assign ram_re    = accept && !fault_in && !(data_mem_write_enable && mem_size[1]);
  assign ram_we    = !rst && ((accept && !fault_in && data_mem_write_enable && mem_size[1])
                              || (state == MERGE));
  assign ram_waddr = (state == MERGE) ? addr_q[ADDR_W+1:2] : addr_in[ADDR_W+1:2];
  assign ram_wdata = (state == MERGE) ? merged : data_mem_write_data;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (ram_re) rdata_q <= ram[addr_in[ADDR_W+1:2]];
  end

  always_comb begin
    merged = rdata_q;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
  end

  always_comb begin
    load_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    load_half = rdata_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{24{!unsigned_q & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{16{!unsigned_q & load_half[15]}}, load_half};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    mem_stall          = 1'b0;
    mem_misaligned     = 1'b0;
    data_mem_read_data = '0;
    case (state)
      IDLE:  mem_stall = req;
      MERGE: mem_stall = 1'b1;
      DONE: begin
        mem_misaligned = fault_q;
        if (!store_q && !fault_q) data_mem_read_data = load_ext;
      end
      default: mem_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl: loads, stores, RMW merges,
// misalignment faults, reset during MERGE, address wrap and back-to-back requests.
module tb_data_mem_ctrl;

  localparam int DEPTH_WORDS = 1024;
  localparam int ADDR_W      = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_mem_write_enable;
  logic [31:0] data_mem_write_addr;
  logic [31:0] data_mem_write_data;
  logic        data_mem_read_enable;
  logic [31:0] data_mem_read_addr;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] data_mem_read_data;
  logic        mem_stall;
  logic        mem_misaligned;

  int checks   = 0;
  int failures = 0;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_mem_write_enable (data_mem_write_enable),
    .data_mem_write_addr   (data_mem_write_addr),
    .data_mem_write_data   (data_mem_write_data),
    .data_mem_read_enable  (data_mem_read_enable),
    .data_mem_read_addr    (data_mem_read_addr),
    .mem_size              (mem_size),
    .mem_unsigned          (mem_unsigned),
    .data_mem_read_data    (data_mem_read_data),
    .mem_stall             (mem_stall),
    .mem_misaligned        (mem_misaligned)
  );

  always #5 clk = ~clk;

  // The unused address port carries a decoy so address-source mixups show up.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    @(negedge clk);
    data_mem_write_enable = we;
    data_mem_read_enable  = 1'b1;
    data_mem_write_addr   = we ? addr : (addr ^ 32'h0000_0107);
    data_mem_read_addr    = we ? (addr ^ 32'h0000_0107) : addr;
    data_mem_write_data   = we ? wdata : 32'h0BAD_F00D;
    mem_size              = size;
    mem_unsigned          = uns;
  endtask

  task automatic drop_request();
    data_mem_write_enable = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_addr   = '0;
    data_mem_read_addr    = '0;
    data_mem_write_data   = '0;
    mem_size              = 2'b00;
    mem_unsigned          = 1'b0;
  endtask

  // Counts stall cycles up to DONE, samples DONE outputs, then spends one IDLE cycle.
  task automatic finish_access(output int cycles, output logic [31:0] rd,
                               output logic mis, output logic mis_after);
    cycles = 0;
    #1;
    while (mem_stall && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    rd  = data_mem_read_data;
    mis = mem_misaligned;
    drop_request();
    @(negedge clk);
    mis_after = mem_misaligned;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_request();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_stall got=%b exp=0", mem_stall);
    end
    checks++;
    if (data_mem_read_data !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_read_data got=%h exp=00000000", data_mem_read_data);
    end
    checks++;
    if (mem_misaligned !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_misaligned got=%b exp=0", mem_misaligned);
    end
    rst = 1'b0;
  endtask

  task automatic test_word_store_load();
    int cyc; logic [31:0] rd; logic mis, mis_a;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (cyc !== 1) begin failures++; $display("[TB] FAIL sw_stall_cycles got=%0d exp=1", cyc); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("[TB] FAIL sw_read_data got=%h exp=00000000", rd); end
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (cyc !== 1) begin failures++; $display("[TB] FAIL lw_stall_cycles got=%0d exp=1", cyc); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lw_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_subword_store();
    int cyc; logic [31:0] rd; logic mis, mis_a;
    issue(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    issue(1'b1, 32'h21, 32'hFFFFFFAA, 2'b00, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (cyc !== 2) begin failures++; $display("[TB] FAIL sb_stall_cycles got=%0d exp=2", cyc); end
    issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (rd !== 32'h1122AA44) begin failures++; $display("[TB] FAIL sb_merge got=%h exp=1122aa44", rd); end
    issue(1'b1, 32'h22, 32'h1234BEEF, 2'b01, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (cyc !== 2) begin failures++; $display("[TB] FAIL sh_stall_cycles got=%0d exp=2", cyc); end
    issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (rd !== 32'hBEEFAA44) begin failures++; $display("[TB] FAIL sh_merge got=%h exp=beefaa44", rd); end
  endtask

  task automatic test_load_extend();
    int cyc; logic [31:0] rd; logic mis, mis_a;
    logic [31:0] addrs [8] = '{32'h31, 32'h32, 32'h32, 32'h32, 32'h30, 32'h33, 32'h30, 32'h30};
    logic [1:0]  sizes [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    logic        unss  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [8] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                               32'h00007F01, 32'hFFFFFF80, 32'h00000001, 32'h00007F01};
    issue(1'b1, 32'h30, 32'h80FF7F01, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, addrs[i], 32'h0, sizes[i], unss[i]);
      finish_access(cyc, rd, mis, mis_a);
      checks++;
      if (rd !== exps[i]) begin
        failures++;
        $display("[TB] FAIL load_ext[%0d] addr=%h size=%b uns=%b got=%h exp=%h",
                 i, addrs[i], sizes[i], unss[i], rd, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    int cyc; logic [31:0] rd; logic mis, mis_a;
    issue(1'b1, 32'h40, 32'h11111111, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (mis !== 1'b0) begin failures++; $display("[TB] FAIL aligned_sw_flag got=%b exp=0", mis); end
    issue(1'b1, 32'h41, 32'h99999999, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (mis !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_sw_flag got=%b exp=1", mis); end
    checks++;
    if (cyc !== 1) begin failures++; $display("[TB] FAIL misaligned_sw_cycles got=%0d exp=1", cyc); end
    checks++;
    if (mis_a !== 1'b0) begin failures++; $display("[TB] FAIL misaligned_pulse got=%b exp=0", mis_a); end
    issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (rd !== 32'h11111111) begin failures++; $display("[TB] FAIL misaligned_no_write got=%h exp=11111111", rd); end
    issue(1'b0, 32'h43, 32'h0, 2'b01, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (mis !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_lh_flag got=%b exp=1", mis); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("[TB] FAIL misaligned_lh_data got=%h exp=00000000", rd); end
  endtask

  task automatic test_reset_in_merge();
    int cyc; logic [31:0] rd; logic mis, mis_a;
    issue(1'b1, 32'h50, 32'hCAFEF00D, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    issue(1'b1, 32'h52, 32'h0000BEEF, 2'b01, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b1) begin failures++; $display("[TB] FAIL merge_stall got=%b exp=1", mem_stall); end
    rst = 1'b1;
    drop_request();
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_merge_stall got=%b exp=0", mem_stall); end
    checks++;
    if (mem_misaligned !== 1'b0 || data_mem_read_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rst_merge_outputs got=%b/%h exp=0/00000000", mem_misaligned, data_mem_read_data);
    end
    rst = 1'b0;
    issue(1'b0, 32'h50, 32'h0, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL rst_merge_no_write got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_wrap();
    int cyc; logic [31:0] rd; logic mis, mis_a;
    issue(1'b1, DEPTH_WORDS * 4, 32'h5A5A5A5A, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    issue(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    finish_access(cyc, rd, mis, mis_a);
    checks++;
    if (rd !== 32'h5A5A5A5A) begin failures++; $display("[TB] FAIL addr_wrap got=%h exp=5a5a5a5a", rd); end
  endtask

  // Holding a request across DONE: ignored in DONE, accepted again in the following IDLE.
  task automatic test_back_to_back();
    logic        exp_stall [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_rd    [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (mem_stall !== exp_stall[i] || data_mem_read_data !== exp_rd[i]) begin
        failures++;
        $display("[TB] FAIL back_to_back[%0d] got=%b/%h exp=%b/%h",
                 i, mem_stall, data_mem_read_data, exp_stall[i], exp_rd[i]);
      end
    end
    drop_request();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_load_extend();
    test_misaligned();
    test_reset_in_merge();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
